// File: rtl/div_timer_pkg.sv
// Shared constants for the divider/timer block: register map, FSM states
// and helpers that locate the CTRL fields for a given number of taps.
package div_timer_pkg;

    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_CNT  = 2'd1;
    localparam logic [1:0] ADDR_MOD  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    // Each TAP_MAP entry is a fixed-width divider bit index.
    localparam int TAP_FIELD_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RELOAD  = 2'd2
    } state_t;

    function automatic int ctrl_sel_w(input int nsel);
        return $clog2(nsel);
    endfunction

    function automatic int ctrl_en_bit(input int nsel);
        return $clog2(nsel);
    endfunction

endpackage

// File: rtl/div_timer_gen_if.sv
// CPU-side register bus of the divider/timer, plus its interrupt and tap outputs.
interface div_timer_gen_if #(
    parameter int CNT_W = 8,
    parameter int NSEL  = 4
);
    logic [1:0]       addr;
    logic             cpu_wr;
    logic             cpu_rd;
    logic [CNT_W-1:0] wdata;
    logic [CNT_W-1:0] rdata;
    logic             irq;
    logic [NSEL-1:0]  tap_out;

    modport master (
        output addr, cpu_wr, cpu_rd, wdata,
        input  rdata, irq, tap_out
    );

    modport slave (
        input  addr, cpu_wr, cpu_rd, wdata,
        output rdata, irq, tap_out
    );
endinterface

// File: rtl/tap_edge_det.sv
// Picks one divider tap, gates it with the enable and flags its falling edge.
module tap_edge_det
    import div_timer_pkg::*;
#(
    parameter int                            DIV_W   = 16,
    parameter int                            NSEL    = 4,
    parameter logic [NSEL*TAP_FIELD_W-1:0]   TAP_MAP = {8'd7, 8'd5, 8'd3, 8'd9}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DIV_W-1:0]        divider,
    input  logic [$clog2(NSEL)-1:0] sel,
    input  logic                    en,
    output logic                    tick,
    output logic [NSEL-1:0]         taps
);

    logic tick_src;
    logic tick_src_q;
    logic unused_div_bits;

    for (genvar i = 0; i < NSEL; i++) begin : g_tap
        localparam int IDX = int'(TAP_MAP[i*TAP_FIELD_W +: TAP_FIELD_W]);
        assign taps[i] = divider[IDX];
    end

    assign unused_div_bits = ^divider;
    assign tick_src        = en & taps[sel];

    // Any 1->0 of the gated source counts, including ones caused by
    // clearing the divider or changing the enable/select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_src_q <= 1'b0;
        else       tick_src_q <= tick_src;
    end

    assign tick = tick_src_q & ~tick_src;

endmodule

// File: rtl/div_timer_gen.sv
// Free-running divider with a tap-clocked counter that overflows into a
// delayed reload from MOD and a one-clock interrupt.
module div_timer_gen
    import div_timer_pkg::*;
#(
    parameter int                          DIV_W      = 16,
    parameter int                          CNT_W      = 8,
    parameter int                          NSEL       = 4,
    parameter logic [NSEL*TAP_FIELD_W-1:0] TAP_MAP    = {8'd7, 8'd5, 8'd3, 8'd9},
    parameter int                          RELOAD_DLY = 4
) (
    input  logic            clk,
    input  logic            reset,
    div_timer_gen_if.slave  bus
);

    localparam int         SEL_W    = ctrl_sel_w(NSEL);
    localparam int         EN_BIT   = ctrl_en_bit(NSEL);
    localparam int         CTRL_W   = EN_BIT + 1;
    localparam logic [3:0] DLY_INIT = 4'(RELOAD_DLY - 1);

    logic [DIV_W-1:0]  divider;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [CNT_W-1:0]  mod_q;
    logic [CTRL_W-1:0] ctrl;
    state_t            state, state_next;
    logic [3:0]        dly, dly_next;
    logic              tick;
    logic              wr_div, wr_cnt, wr_mod, wr_ctrl;

    assign wr_div  = bus.cpu_wr && (bus.addr == ADDR_DIV);
    assign wr_cnt  = bus.cpu_wr && (bus.addr == ADDR_CNT);
    assign wr_mod  = bus.cpu_wr && (bus.addr == ADDR_MOD);
    assign wr_ctrl = bus.cpu_wr && (bus.addr == ADDR_CTRL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       divider <= '0;
        else if (wr_div) divider <= '0;
        else             divider <= divider + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mod_q <= '0;
            ctrl  <= '0;
        end else begin
            if (wr_mod)  mod_q <= bus.wdata;
            if (wr_ctrl) ctrl  <= bus.wdata[CTRL_W-1:0];
        end
    end

    tap_edge_det #(
        .DIV_W   (DIV_W),
        .NSEL    (NSEL),
        .TAP_MAP (TAP_MAP)
    ) u_tap (
        .clk     (clk),
        .reset   (reset),
        .divider (divider),
        .sel     (ctrl[SEL_W-1:0]),
        .en      (ctrl[EN_BIT]),
        .tick    (tick),
        .taps    (bus.tap_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            dly   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            dly   <= dly_next;
            cnt   <= cnt_next;
        end
    end

    // The reload value is latched on entry to RELOAD so CNT already shows it
    // while irq is high; a MOD write during RELOAD then overrides it.
    always_comb begin
        state_next = state;
        dly_next   = dly;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (wr_cnt) begin
                    cnt_next = bus.wdata;
                end else if (tick) begin
                    cnt_next = cnt + 1'b1;
                    if (&cnt) begin
                        state_next = PENDING;
                        dly_next   = DLY_INIT;
                    end
                end
            end
            PENDING: begin
                if (wr_cnt) begin
                    cnt_next   = bus.wdata;
                    state_next = IDLE;
                end else if (dly == 4'd0) begin
                    cnt_next   = wr_mod ? bus.wdata : mod_q;
                    state_next = RELOAD;
                end else begin
                    dly_next = dly - 4'd1;
                end
            end
            RELOAD: begin
                if (wr_mod) cnt_next = bus.wdata;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.irq = (state == RELOAD);

    always_comb begin
        bus.rdata = '0;
        if (bus.cpu_rd) begin
            case (bus.addr)
                ADDR_DIV:  bus.rdata = divider[DIV_W-1 -: CNT_W];
                ADDR_CNT:  bus.rdata = cnt;
                ADDR_MOD:  bus.rdata = mod_q;
                ADDR_CTRL: bus.rdata = {{(CNT_W-CTRL_W){1'b1}}, ctrl};
                default:   bus.rdata = '0;
            endcase
        end
    end

endmodule
